// File: rtl/toggle_cov_pkg.sv
// toggle_cov_pkg
// Shared definitions for the toggle-coverage feeder blocks.
//   TOGGLE_RISE_BASE : index of the first rise event in the event vector
//   TOGGLE_FALL_OFS  : index of the first fall event at the default width
//                      (a block built with another WIDTH uses WIDTH itself)
//   cov_sat_add      : saturating add used by the event counter
package toggle_cov_pkg;

  localparam int TOGGLE_DEFAULT_WIDTH = 20;
  localparam int TOGGLE_RISE_BASE     = 0;
  localparam int TOGGLE_FALL_OFS      = TOGGLE_DEFAULT_WIDTH;

  // Adds a and b and clamps the result at max. The 33-bit sum keeps the carry
  // so a large addend can never wrap past the limit.
  function automatic logic [31:0] cov_sat_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] max);
    logic [32:0] sum;
    logic [31:0] result;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      result = max;
    end else begin
      result = sum[31:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/toggle_popcount.sv
// toggle_popcount
// Combinational population count of a W-bit vector.
// Ports:
//   vec  in   W                 vector to count
//   cnt  out  $clog2(W+1)       number of set bits in vec
module toggle_popcount #(
  parameter int W = 40
) (
  input  logic [W-1:0]           vec,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/toggle_event_gen.sv
// toggle_event_gen
// Turns rising and falling transitions of the watched signal bits into
// one-cycle event pulses for the toggle-coverage reporter, optionally
// reporting each coverage point only on its first hit, and keeps a
// saturating count of reported events plus an all-covered flag.
// Ports:
//   clock        in   1         sole clock
//   reset        in   1         synchronous, active-high
//   sig_in       in   WIDTH     watched signal bits, sampled every clock
//   en           in   1         event generation enable
//   clear        in   1         synchronous restart of coverage state
//   valid        out  2*WIDTH   event pulses: bit i = rise of sig_in[i],
//                               bit WIDTH+i = fall of sig_in[i]
//   hit_count    out  CNT_W     events reported since reset/clear, saturating
//   all_covered  out  1         every point has been hit (STICKY=1 only)
module toggle_event_gen
  import toggle_cov_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int STICKY = 1,
  parameter int CNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   sig_in,
  input  logic               en,
  input  logic               clear,
  output logic [2*WIDTH-1:0] valid,
  output logic [CNT_W-1:0]   hit_count,
  output logic               all_covered
);

  localparam int EV_W     = 2 * WIDTH;
  localparam int PC_W     = $clog2(EV_W + 1);
  localparam int FALL_OFS = WIDTH;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [WIDTH-1:0] prev;
  logic             armed;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [EV_W-1:0]  raw_events;
  logic [EV_W-1:0]  new_events;
  logic [PC_W-1:0]  new_count;
  logic [CNT_W-1:0] hit_count_next;
  logic             all_covered_next;

  // Events only once armed, so the first enabled cycle after reset/clear
  // just captures a reference value instead of reporting against it.
  always_comb begin
    rise = {WIDTH{armed & en}} & ~prev &  sig_in;
    fall = {WIDTH{armed & en}} &  prev & ~sig_in;
    raw_events = '0;
    raw_events[TOGGLE_RISE_BASE +: WIDTH] = rise;
    raw_events[FALL_OFS +: WIDTH]         = fall;
  end

  generate
    if (STICKY != 0) begin : g_sticky
      logic [EV_W-1:0] covered;

      always_ff @(posedge clock) begin
        if (reset || clear) begin
          covered <= '0;
        end else begin
          covered <= covered | new_events;
        end
      end

      assign new_events       = raw_events & ~covered;
      assign all_covered_next = &(covered | new_events);
    end else begin : g_plain
      assign new_events       = raw_events;
      assign all_covered_next = 1'b0;
    end
  endgenerate

  toggle_popcount #(
    .W(EV_W)
  ) u_popcount (
    .vec(new_events),
    .cnt(new_count)
  );

  assign hit_count_next = CNT_W'(cov_sat_add(32'(hit_count), 32'(new_count), CNT_MAX));

  // prev tracks sig_in even while disabled or clearing, so toggles that
  // happen with en low are simply lost rather than reported late.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev        <= '0;
      armed       <= 1'b0;
      valid       <= '0;
      hit_count   <= '0;
      all_covered <= 1'b0;
    end else begin
      prev <= sig_in;
      if (clear) begin
        armed       <= 1'b0;
        valid       <= '0;
        hit_count   <= '0;
        all_covered <= 1'b0;
      end else begin
        if (en) begin
          armed <= 1'b1;
        end
        valid       <= new_events;
        hit_count   <= hit_count_next;
        all_covered <= all_covered_next;
      end
    end
  end

endmodule
